// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between the bridge's master port and the memory target.
interface apb_mem_slave_if;
  logic        sel_sig_master;
  logic        en_from_master;
  logic        write_sig_master;
  logic [15:0] addr_from_master;
  logic [31:0] write_data_master;
  logic        ready_master;
  logic [31:0] read_data_master;

  modport master (
    output sel_sig_master, en_from_master, write_sig_master,
           addr_from_master, write_data_master,
    input  ready_master, read_data_master
  );

  modport slave (
    input  sel_sig_master, en_from_master, write_sig_master,
           addr_from_master, write_data_master,
    output ready_master, read_data_master
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB target: word-addressed flop memory with fixed wait states and a
// saturating protocol-violation counter.
module apb_mem_slave #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] BASE_ADDR   = 16'h0000
) (
  input  logic                  clk_apb,
  input  logic                  rst_apb,
  apb_mem_slave_if.slave        bus,
  output logic [7:0]            prot_err_count
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP_SEEN, ACCESS, ERR_ABORT} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_in_range;
  logic          r_write;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [7:0]    r_err_cnt;
  logic [31:0]   r_mem [DEPTH];

  logic [13:0]   w_woff;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_sel;
  logic          w_en;
  logic          w_take_setup;
  logic          w_access;
  logic          w_ready;
  logic          w_err_inc;

  assign w_sel      = bus.sel_sig_master;
  assign w_en       = bus.en_from_master;
  // BASE_ADDR is word-aligned, so the word offset is a plain 14-bit difference.
  assign w_woff     = bus.addr_from_master[15:2] - BASE_ADDR[15:2];
  assign w_idx      = w_woff[AW-1:0];
  assign w_in_range = (bus.addr_from_master >= BASE_ADDR) && (32'(w_woff) < DEPTH);

  assign w_take_setup = w_sel && !w_en && ((r_state == IDLE) || (r_state == ERR_ABORT));
  // The first enable cycle is still spent in SETUP_SEEN, so it can complete too.
  assign w_access     = (r_state == SETUP_SEEN) || (r_state == ACCESS);
  assign w_ready      = w_access && (r_cnt == 4'd0) && w_sel && w_en;
  assign w_err_inc    = (r_state == ERR_ABORT) || ((r_state == IDLE) && w_sel && w_en);

  assign bus.ready_master     = w_ready;
  assign bus.read_data_master = r_rdata;
  assign prot_err_count       = r_err_cnt;

  always_ff @(posedge clk_apb) begin
    if (!rst_apb) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_in_range <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_err_cnt  <= 8'd0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
    end else begin
      if (w_take_setup) begin
        r_idx      <= w_idx;
        r_in_range <= w_in_range;
        r_write    <= bus.write_sig_master;
        r_wdata    <= bus.write_data_master;
        r_cnt      <= 4'(WAIT_CYCLES);
        if (!bus.write_sig_master) r_rdata <= w_in_range ? r_mem[w_idx] : 32'hDEAD_BEEF;
      end

      if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;

      if (w_ready && r_write && r_in_range) r_mem[r_idx] <= r_wdata;

      case (r_state)
        IDLE:       if (w_take_setup) r_state <= SETUP_SEEN;
        SETUP_SEEN, ACCESS: begin
          if (!w_sel || !w_en) begin
            r_state <= ERR_ABORT;
          end else if (r_cnt != 4'd0) begin
            r_cnt   <= r_cnt - 4'd1;
            r_state <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        ERR_ABORT:  r_state <= w_take_setup ? SETUP_SEEN : IDLE;
        default:    r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench: default-parameter target plus a zero-wait, offset-base target.
module tb_apb_mem_slave;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  apb_mem_slave_if ifa();
  apb_mem_slave_if ifz();
  logic [7:0] err_a;
  logic [7:0] err_z;

  apb_mem_slave #(.DEPTH(64), .WAIT_CYCLES(2), .BASE_ADDR(16'h0000)) dut_a (
    .clk_apb(clk), .rst_apb(rst_b), .bus(ifa), .prot_err_count(err_a));
  apb_mem_slave #(.DEPTH(64), .WAIT_CYCLES(0), .BASE_ADDR(16'h4000)) dut_z (
    .clk_apb(clk), .rst_apb(rst_b), .bus(ifz), .prot_err_count(err_z));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad = 0;
  int last_ready_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic set_bus(input bit w, input bit sel, input bit en, input bit wr,
                         input logic [15:0] addr, input logic [31:0] wd);
    if (w) begin
      ifz.sel_sig_master = sel; ifz.en_from_master = en; ifz.write_sig_master = wr;
      ifz.addr_from_master = addr; ifz.write_data_master = wd;
    end else begin
      ifa.sel_sig_master = sel; ifa.en_from_master = en; ifa.write_sig_master = wr;
      ifa.addr_from_master = addr; ifa.write_data_master = wd;
    end
  endtask

  function automatic logic get_ready(input bit w);
    return w ? ifz.ready_master : ifa.ready_master;
  endfunction

  function automatic logic [31:0] get_rdata(input bit w);
    return w ? ifz.read_data_master : ifa.read_data_master;
  endfunction

  // One transfer starting #1 after an edge; acc = access cycle of ready (0 = none).
  task automatic xfer(input bit w, input bit wr, input logic [15:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output int acc);
    int cs;
    acc = 0;
    rd  = 32'hxxxx_xxxx;
    cs  = cyc;
    set_bus(w, 1'b1, 1'b0, wr, addr, wd);
    @(posedge clk); #1;
    set_bus(w, 1'b1, 1'b1, wr, addr, wd);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (get_ready(w)) begin
        acc = cyc - cs;
        last_ready_cyc = cyc;
        rd = get_rdata(w);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    set_bus(w, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic abort_once();
    set_bus(0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
    @(posedge clk); #1;
    set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    int acc;
    int c0;
    logic seen;

    set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    set_bus(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ifa.ready_master), 32'd0);
    check("rst_rdata", ifa.read_data_master, 32'd0);
    check("rst_errcnt", 32'(err_a), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;

    xfer(0, 1'b0, 16'h0010, 32'h0, rd, acc);
    check("rd10_latency", acc, 3);
    check("rd10_data", rd, 32'd0);
    check("rd10_errcnt", 32'(err_a), 32'd0);

    c0 = cyc;
    xfer(0, 1'b1, 16'h00FC, 32'hA5A5_1234, rd, acc);
    check("wrFC_latency", acc, 3);
    xfer(0, 1'b0, 16'h00FC, 32'h0, rd, acc);
    check("rdFC_data", rd, 32'hA5A5_1234);
    check("b2b_total_cycles", last_ready_cyc - c0 + 1, 8);

    xfer(0, 1'b0, 16'h0100, 32'h0, rd, acc);
    check("oor_rd_data", rd, 32'hDEAD_BEEF);
    check("oor_rd_latency", acc, 3);
    xfer(0, 1'b1, 16'h0100, 32'h1, rd, acc);
    check("oor_wr_latency", acc, 3);
    xfer(0, 1'b0, 16'h0000, 32'h0, rd, acc);
    check("idx0_after_oor_wr", rd, 32'd0);
    check("oor_errcnt", 32'(err_a), 32'd0);

    xfer(1, 1'b1, 16'h4008, 32'h0000_CAFE, rd, acc);
    check("z_wr_latency", acc, 1);
    xfer(1, 1'b0, 16'h4008, 32'h0, rd, acc);
    check("z_rd_latency", acc, 1);
    check("z_rd_data", rd, 32'h0000_CAFE);
    xfer(1, 1'b0, 16'h3FFC, 32'h0, rd, acc);
    check("z_below_base", rd, 32'hDEAD_BEEF);
    xfer(1, 1'b0, 16'h4100, 32'h0, rd, acc);
    check("z_above_top", rd, 32'hDEAD_BEEF);
    check("z_errcnt", 32'(err_z), 32'd0);

    // Enable dropped in access cycle 2 of a write to idx 3.
    seen = 1'b0;
    set_bus(0, 1'b1, 1'b0, 1'b1, 16'h000C, 32'h1234_5678);
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b1, 1'b1, 16'h000C, 32'h1234_5678);
    @(negedge clk); seen |= ifa.ready_master;
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b0, 1'b1, 16'h000C, 32'h1234_5678);
    @(negedge clk); seen |= ifa.ready_master;
    @(posedge clk); #1;
    set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk); seen |= ifa.ready_master;
    @(posedge clk); #1;
    check("abort_no_ready", 32'(seen), 32'd0);
    check("abort_errcnt", 32'(err_a), 32'd1);
    xfer(0, 1'b0, 16'h000C, 32'h0, rd, acc);
    check("abort_mem_unchanged", rd, 32'd0);

    set_bus(0, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0);
    @(negedge clk); seen = ifa.ready_master;
    @(posedge clk); #1;
    set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    check("stray_no_ready", 32'(seen), 32'd0);
    check("stray_errcnt", 32'(err_a), 32'd2);

    for (int i = 0; i < 252; i++) abort_once();
    check("errcnt_254", 32'(err_a), 32'd254);
    abort_once();
    check("errcnt_255", 32'(err_a), 32'd255);
    for (int i = 0; i < 5; i++) abort_once();
    check("errcnt_saturated", 32'(err_a), 32'd255);

    xfer(0, 1'b1, 16'h0014, 32'h0000_0055, rd, acc);
    check("idx5_wr_latency", acc, 3);
    xfer(0, 1'b0, 16'h00FC, 32'h0, rd, acc);
    check("pre_rst_rdata", rd, 32'hA5A5_1234);

    // Reset asserted in access cycle 1 of a write to idx 5.
    set_bus(0, 1'b1, 1'b0, 1'b1, 16'h0014, 32'hFFFF_0000);
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b1, 1'b1, 16'h0014, 32'hFFFF_0000);
    rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", 32'(ifa.ready_master), 32'd0);
    check("midrst_errcnt", 32'(err_a), 32'd0);
    check("midrst_rdata", ifa.read_data_master, 32'd0);
    @(posedge clk); #1;
    set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    rst_b = 1'b1;
    xfer(0, 1'b0, 16'h0014, 32'h0, rd, acc);
    check("midrst_idx5", rd, 32'd0);
    check("midrst_errcnt_after", 32'(err_a), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
